pa_lsu_sram_ctrl: RTL and testbench

PA_LSU_SRAM_CTRL -- requirements
Module: pa_lsu_sram_ctrl

---
 rtl/pa_lsu_sram_ctrl_if.sv | 27 ++
 rtl/pa_lsu_sram_ctrl.sv | 138 +++++++++++++
 tb/tb_pa_lsu_sram_ctrl.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pa_lsu_sram_ctrl_if.sv
// Request/response handshake bundle between an LSU client and pa_lsu_sram_ctrl.
// master drives requests and consumes responses; slave is the controller.
interface pa_lsu_sram_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BE_WIDTH   = 4
);
  logic                  req_vld;
  logic                  req_rdy;
  logic                  req_wr;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [BE_WIDTH-1:0]   req_be;
  logic                  resp_vld;
  logic                  resp_rdy;
  logic [DATA_WIDTH-1:0] resp_rdata;

  modport master (
    output req_vld, req_wr, req_addr, req_wdata, req_be, resp_rdy,
    input  req_rdy, resp_vld, resp_rdata
  );

  modport slave (
    input  req_vld, req_wr, req_addr, req_wdata, req_be, resp_rdy,
    output req_rdy, resp_vld, resp_rdata
  );
endinterface

// File: rtl/pa_lsu_sram_ctrl.sv
// LSU-side single-port SRAM controller: one-cycle read latency with a hold buffer for backpressure.
// Optional power-on array clear enabled by macro PA_LSU_SRAM_INIT_EN.
module pa_lsu_sram_ctrl #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BE_WIDTH   = 4
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  pa_lsu_sram_ctrl_if.slave     bus,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic [DATA_WIDTH-1:0] sram_d,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  localparam int unsigned BYTE_W = DATA_WIDTH / BE_WIDTH;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    HOLD    = 2'd2
`ifdef PA_LSU_SRAM_INIT_EN
    , INIT  = 2'd3
`endif
  } state_e;

`ifdef PA_LSU_SRAM_INIT_EN
  localparam state_e RST_STATE = INIT;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  init_done_q, init_done_d;
  assign init_done = init_done_q;
`else
  localparam state_e RST_STATE = IDLE;
  assign init_done = 1'b1;
`endif

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  rdy;
  logic                  fire;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q     <= RST_STATE;
      hold_q      <= '0;
`ifdef PA_LSU_SRAM_INIT_EN
      cnt_q       <= '0;
      init_done_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
`ifdef PA_LSU_SRAM_INIT_EN
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
`endif
    end
  end

  always_comb begin
    state_d        = state_q;
    hold_d         = hold_q;
`ifdef PA_LSU_SRAM_INIT_EN
    cnt_d          = cnt_q;
    init_done_d    = init_done_q;
`endif
    rdy            = 1'b0;
    fire           = 1'b0;
    bus.resp_vld   = 1'b0;
    bus.resp_rdata = '0;
    sram_a         = '0;
    sram_d         = '0;
    sram_cen       = 1'b1;
    sram_gwen      = 1'b1;
    sram_wen       = '1;

    case (state_q)
      IDLE: rdy = cpurst_b;
      RD_WAIT: begin
        rdy            = cpurst_b & bus.resp_rdy;
        bus.resp_vld   = 1'b1;
        bus.resp_rdata = sram_q;
        if (bus.resp_rdy) begin
          state_d = IDLE;
        end else begin
          // SRAM output is only valid for one cycle; park it until consumed
          state_d = HOLD;
          hold_d  = sram_q;
        end
      end
      HOLD: begin
        bus.resp_vld   = 1'b1;
        bus.resp_rdata = hold_q;
        if (bus.resp_rdy) state_d = IDLE;
      end
`ifdef PA_LSU_SRAM_INIT_EN
      INIT: begin
        if (cpurst_b) begin
          sram_cen  = 1'b0;
          sram_gwen = 1'b0;
          sram_wen  = '0;
          sram_a    = cnt_q;
          cnt_d     = cnt_q + ADDR_WIDTH'(1);
          if (cnt_q == '1) begin
            state_d     = IDLE;
            init_done_d = 1'b1;
          end
        end
      end
`endif
      default: state_d = RST_STATE;
    endcase

    // Accepted request drives the SRAM in the same cycle
    fire = bus.req_vld & rdy;
    if (fire) begin
      sram_a = bus.req_addr;
      sram_d = bus.req_wdata;
      if (bus.req_wr) begin
        sram_gwen = 1'b0;
        for (int i = 0; i < int'(BE_WIDTH); i++) begin
          sram_wen[i*BYTE_W +: BYTE_W] = {BYTE_W{~bus.req_be[i]}};
        end
        sram_cen = ~(|bus.req_be);
      end else begin
        sram_cen = 1'b0;
        state_d  = RD_WAIT;
      end
    end

    bus.req_rdy = rdy;
  end

endmodule

// File: tb/tb_pa_lsu_sram_ctrl.sv
// Self-checking bench for pa_lsu_sram_ctrl: directed vector table, handshake corner sequences,
// and random traffic against a request-level memory/response-queue model.
module tb_pa_lsu_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        init_done;
  logic [7:0]  sram_a;
  logic [31:0] sram_d;
  logic        sram_cen;
  logic        sram_gwen;
  logic [31:0] sram_wen;
  logic [31:0] sram_q;

  int n_cmp = 0;
  int n_err = 0;

  pa_lsu_sram_ctrl_if bus ();

  pa_lsu_sram_ctrl dut (
    .forever_cpuclk (clk),
    .cpurst_b       (rst_n),
    .bus            (bus),
    .init_done      (init_done),
    .sram_a         (sram_a),
    .sram_d         (sram_d),
    .sram_cen       (sram_cen),
    .sram_gwen      (sram_gwen),
    .sram_wen       (sram_wen),
    .sram_q         (sram_q)
  );

  always #5 clk = ~clk;

  // SRAM array model driven only by the DUT pins
  logic [31:0] mem [256];
  bit          mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= {4{8'(i)}} ^ 32'h5A5A_5A5A;
      mem_ready <= 1'b1;
    end else if (!sram_cen) begin
      if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else            sram_q <= mem[sram_a];
    end
  end

  logic [31:0] shadow [256];

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_wen;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic vec_t mk(input bit wr, input logic [7:0] a, input logic [31:0] d,
                              input logic [3:0] be, input logic [31:0] wen,
                              input logic [31:0] rd);
    vec_t v;
    v.wr = wr; v.addr = a; v.wdata = d; v.be = be; v.exp_wen = wen; v.exp_rdata = rd;
    return v;
  endfunction

  task automatic apply_vec(input vec_t v);
    @(posedge clk); #1;
    bus.req_vld = 1'b1; bus.req_wr = v.wr; bus.req_addr = v.addr;
    bus.req_wdata = v.wdata; bus.req_be = v.be; bus.resp_rdy = 1'b1;
    @(negedge clk);
    chk("vec_req_rdy", 32'(bus.req_rdy), 32'd1);
    chk("vec_sram_a", 32'(sram_a), 32'(v.addr));
    if (v.wr) begin
      chk("vec_wr_cen", 32'(sram_cen), 32'(v.be == 4'b0000));
      chk("vec_wr_gwen", 32'(sram_gwen), 32'd0);
      chk("vec_wr_wen", sram_wen, v.exp_wen);
      chk("vec_wr_d", sram_d, v.wdata);
      shadow[v.addr] = merge(shadow[v.addr], v.wdata, v.be);
    end else begin
      chk("vec_rd_cen", 32'(sram_cen), 32'd0);
      chk("vec_rd_gwen", 32'(sram_gwen), 32'd1);
    end
    @(posedge clk); #1;
    bus.req_vld = 1'b0;
    @(negedge clk);
    chk("vec_resp_vld", 32'(bus.resp_vld), 32'(!v.wr));
    if (!v.wr) chk("vec_rdata", bus.resp_rdata, v.exp_rdata);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_vld = 1'b1; bus.req_wr = 1'b0; bus.req_addr = 8'h00; bus.resp_rdy = 1'b1;
    #1;
    chk("rst_resp_vld", 32'(bus.resp_vld), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_req_rdy", 32'(bus.req_rdy), 32'd0);
      chk("rst_cen", 32'(sram_cen), 32'd1);
      chk("rst_resp_vld", 32'(bus.resp_vld), 32'd0);
`ifdef PA_LSU_SRAM_INIT_EN
      chk("rst_init_done", 32'(init_done), 32'd0);
`else
      chk("rst_init_done", 32'(init_done), 32'd1);
`endif
    end
    @(posedge clk); #1;
    rst_n = 1'b1; bus.req_vld = 1'b0;
`ifdef PA_LSU_SRAM_INIT_EN
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      chk("init_done_low", 32'(init_done), 32'd0);
      chk("init_req_rdy", 32'(bus.req_rdy), 32'd0);
      chk("init_cen", 32'(sram_cen), 32'd0);
      chk("init_a", 32'(sram_a), 32'(i));
      chk("init_resp_vld", 32'(bus.resp_vld), 32'd0);
    end
    for (int i = 0; i < 256; i++) shadow[i] = 32'h0;
`endif
    @(negedge clk);
    chk("post_rst_init_done", 32'(init_done), 32'd1);
    chk("post_rst_req_rdy", 32'(bus.req_rdy), 32'd1);
    chk("post_rst_resp_vld", 32'(bus.resp_vld), 32'd0);
    chk("post_rst_rdata", bus.resp_rdata, 32'd0);
  endtask

  logic [31:0] exp_q [$];
  int          age;
  logic        e_rdy, e_vld, fire;

  initial begin
    bus.req_vld = 1'b0; bus.req_wr = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_be = '0; bus.resp_rdy = 1'b0;
    for (int i = 0; i < 256; i++) shadow[i] = {4{8'(i)}} ^ 32'h5A5A_5A5A;

    vecs[0] = mk(1'b1, 8'h10, 32'hA5A5_1234, 4'hF, 32'h0000_0000, 32'h0);
    vecs[1] = mk(1'b0, 8'h10, 32'h0,         4'h0, 32'hFFFF_FFFF, 32'hA5A5_1234);
    vecs[2] = mk(1'b1, 8'h10, 32'hFFFF_FFFF, 4'h5, 32'hFF00_FF00, 32'h0);
    vecs[3] = mk(1'b0, 8'h10, 32'h0,         4'h0, 32'hFFFF_FFFF, 32'hA5FF_12FF);
    vecs[4] = mk(1'b1, 8'h30, 32'h1234_5678, 4'hF, 32'h0000_0000, 32'h0);
    vecs[5] = mk(1'b1, 8'h30, 32'hDEAD_BEEF, 4'h0, 32'hFFFF_FFFF, 32'h0);
    vecs[6] = mk(1'b0, 8'h30, 32'h0,         4'h0, 32'hFFFF_FFFF, 32'h1234_5678);
    vecs[7] = mk(1'b1, 8'h20, 32'h1111_1111, 4'hF, 32'h0000_0000, 32'h0);
    vecs[8] = mk(1'b1, 8'h21, 32'h2222_2222, 4'hF, 32'h0000_0000, 32'h0);

    #2;
    do_reset();

    for (int i = 0; i < 9; i++) apply_vec(vecs[i]);

    // Backpressure: response parked for three cycles while the next read waits
    @(posedge clk); #1;
    bus.req_vld = 1'b1; bus.req_wr = 1'b0; bus.req_addr = 8'h20; bus.resp_rdy = 1'b0;
    @(negedge clk);
    chk("hold_first_rdy", 32'(bus.req_rdy), 32'd1);
    @(posedge clk); #1;
    bus.req_addr = 8'h21;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_req_rdy", 32'(bus.req_rdy), 32'd0);
      chk("hold_resp_vld", 32'(bus.resp_vld), 32'd1);
      chk("hold_rdata", bus.resp_rdata, 32'h1111_1111);
      @(posedge clk); #1;
    end
    bus.resp_rdy = 1'b1;
    @(negedge clk);
    chk("hold_release_rdy", 32'(bus.req_rdy), 32'd0);
    chk("hold_release_vld", 32'(bus.resp_vld), 32'd1);
    chk("hold_release_data", bus.resp_rdata, 32'h1111_1111);
    chk("hold_release_cen", 32'(sram_cen), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("next_accept_rdy", 32'(bus.req_rdy), 32'd1);
    chk("next_accept_cen", 32'(sram_cen), 32'd0);
    chk("next_accept_a", 32'(sram_a), 32'h21);
    chk("next_accept_idle_vld", 32'(bus.resp_vld), 32'd0);
    @(posedge clk); #1;
    bus.req_vld = 1'b0;
    @(negedge clk);
    chk("next_accept_vld", 32'(bus.resp_vld), 32'd1);
    chk("next_accept_data", bus.resp_rdata, 32'h2222_2222);

    // Streaming reads: one per cycle, no bubbles
    for (int i = 0; i < 8; i++) apply_vec(mk(1'b1, 8'(i), 32'hC0DE_0000 + 32'(i), 4'hF, 32'h0, 32'h0));
    @(posedge clk); #1;
    bus.req_vld = 1'b1; bus.req_wr = 1'b0; bus.req_addr = 8'h00; bus.resp_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("b2b_req_rdy", 32'(bus.req_rdy), 32'd1);
      if (i > 0) begin
        chk("b2b_vld", 32'(bus.resp_vld), 32'd1);
        chk("b2b_data", bus.resp_rdata, 32'hC0DE_0000 + 32'(i - 1));
      end
      @(posedge clk); #1;
      if (i < 7) bus.req_addr = 8'(i + 1);
      else       bus.req_vld = 1'b0;
    end
    @(negedge clk);
    chk("b2b_last_vld", 32'(bus.resp_vld), 32'd1);
    chk("b2b_last_data", bus.resp_rdata, 32'hC0DE_0007);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b_drain_vld", 32'(bus.resp_vld), 32'd0);

    // Random traffic against the request-level model
    age = 0;
    for (int n = 0; n < 400; n++) begin
      @(posedge clk); #1;
      if (n < 390) begin
        bus.req_vld   = 1'($urandom_range(0, 1));
        bus.req_wr    = ($urandom_range(0, 2) == 0);
        bus.req_addr  = 8'($urandom_range(0, 255));
        bus.req_wdata = $urandom;
        bus.req_be    = 4'($urandom_range(0, 15));
        bus.resp_rdy  = ($urandom_range(0, 3) != 0);
      end else begin
        bus.req_vld  = 1'b0;
        bus.resp_rdy = 1'b1;
      end
      @(negedge clk);
      e_vld = (exp_q.size() != 0);
      e_rdy = !e_vld ? 1'b1 : ((age == 0) ? bus.resp_rdy : 1'b0);
      chk("rnd_req_rdy", 32'(bus.req_rdy), 32'(e_rdy));
      chk("rnd_resp_vld", 32'(bus.resp_vld), 32'(e_vld));
      chk("rnd_rdata", bus.resp_rdata, e_vld ? exp_q[0] : 32'h0);
      fire = bus.req_vld & e_rdy;
      chk("rnd_cen", 32'(sram_cen), 32'(!(fire && (!bus.req_wr || bus.req_be != 4'b0000))));
      if (e_vld && bus.resp_rdy) void'(exp_q.pop_front());
      else if (e_vld) age++;
      if (fire) begin
        if (bus.req_wr) shadow[bus.req_addr] = merge(shadow[bus.req_addr], bus.req_wdata, bus.req_be);
        else begin
          exp_q.push_back(shadow[bus.req_addr]);
          age = 0;
        end
      end
    end
    chk("rnd_drained", 32'(exp_q.size()), 32'd0);

    // Reset while a read response is outstanding
    apply_vec(mk(1'b1, 8'h50, 32'h0BAD_F00D, 4'hF, 32'h0, 32'h0));
    @(posedge clk); #1;
    bus.req_vld = 1'b1; bus.req_wr = 1'b0; bus.req_addr = 8'h50; bus.resp_rdy = 1'b0;
    @(negedge clk);
    chk("midrst_fire_rdy", 32'(bus.req_rdy), 32'd1);
    @(posedge clk); #1;
    bus.req_vld = 1'b0;
    @(negedge clk);
    chk("midrst_pending_vld", 32'(bus.resp_vld), 32'd1);
    #1;
    do_reset();
    @(negedge clk);
    chk("midrst_no_resp", 32'(bus.resp_vld), 32'd0);
    apply_vec(mk(1'b0, 8'h50, 32'h0, 4'h0, 32'hFFFF_FFFF, shadow[8'h50]));
    apply_vec(mk(1'b0, 8'h10, 32'h0, 4'h0, 32'hFFFF_FFFF, shadow[8'h10]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
